// File: rtl/sched_pkg.sv
// Shared types for the warp scheduler: opcode constants,
// the push FSM state encoding and the warp id type.
package sched_pkg;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_LD     = 4'd1;
  localparam logic [3:0] OP_ST     = 4'd2;
  localparam logic [3:0] OP_ALU_LO = 4'd3;
  localparam logic [3:0] OP_ALU_HI = 4'd7;
  localparam logic [3:0] OP_MMUL   = 4'd8;
  localparam logic [3:0] OP_HALT   = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    PUSH,
    WAIT
  } push_state_t;

  typedef logic [1:0] warp_id_t;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_LD,
    CL_ST,
    CL_ALU,
    CL_MMUL,
    CL_HALT
  } op_class_t;

  // Unlisted opcodes fall through to NOP.
  function automatic op_class_t classify(
    input logic [3:0] op
  );
    op_class_t c;
    c = CL_NOP;
    unique case (1'b1)
      (op == OP_LD):   c = CL_LD;
      (op == OP_ST):   c = CL_ST;
      (op >= OP_ALU_LO && op <= OP_ALU_HI):
                       c = CL_ALU;
      (op == OP_MMUL): c = CL_MMUL;
      (op == OP_HALT): c = CL_HALT;
      default:         c = CL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/push_sequencer.sv
// Matmul push FSM: PUSH_LEN FIFO reads, then hold
// push_en until the push unit reports completion.
module push_sequencer
  import sched_pkg::*;
#(
  parameter int PUSH_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic matmul_done,
  output logic idle,
  output logic fifo_read_en,
  output logic push_en
);

  localparam int RC_W =
    (PUSH_LEN > 1) ? $clog2(PUSH_LEN) : 1;
  localparam logic [RC_W-1:0] RC_LAST =
    RC_W'(PUSH_LEN - 1);

  push_state_t     state_q, state_d;
  logic [RC_W-1:0] rd_cnt_q, rd_cnt_d;
  logic            rd_en_q, rd_en_d;
  logic            push_q, push_d;

  // Next state, read counter and registered strobes.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = PUSH;
          rd_cnt_d = '0;
        end
      end
      PUSH: begin
        if (rd_cnt_q == RC_LAST) begin
          state_d  = WAIT;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + RC_W'(1);
        end
      end
      WAIT: begin
        if (matmul_done) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        rd_cnt_d = '0;
      end
    endcase
    rd_en_d = (state_d == PUSH);
    push_d  = (state_d != IDLE);
  end

  // FSM state and its decoded outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      rd_cnt_q <= '0;
      rd_en_q  <= 1'b0;
      push_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      rd_en_q  <= rd_en_d;
      push_q   <= push_d;
    end
  end

  assign idle         = (state_q == IDLE);
  assign fifo_read_en = rd_en_q;
  assign push_en      = push_q;

endmodule

// File: rtl/warp_issue_controller.sv
// Per-cycle issue sequencer for the warp scheduler.
// Optional: define PERF_COUNTERS_EN for issue/stall counters.
module warp_issue_controller
  import sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PUSH_LEN   = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [1:0] instr_warp,
  input  logic [3:0] opcode,
  input  logic [3:0] target_reg,
  input  logic [3:0] threads_mask,
  input  logic       matmul_done,
  output logic       instr_accept,
  output logic       buffer_write_en,
  output logic [3:0] pc_update_en,
  output logic       busy_en,
  output logic [3:0] threads_mask_busy,
  output logic       fifo_write_en,
  output logic [3:0] fifo_write_reg,
  output logic       fifo_read_en,
  output logic       push_en,
  output logic       stall,
  output logic [3:0] halted
`ifdef PERF_COUNTERS_EN
  ,
  output logic [15:0] issue_count,
  output logic [15:0] stall_count
`endif
);

  op_class_t        cls;
  warp_id_t         warp;
  logic             active;
  logic             stall_cond;
  logic             acc;
  logic             seq_idle;
  logic [3:0]       warp_oh;
  logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
  logic [3:0]       halted_q, halted_d;

  assign cls     = classify(opcode);
  assign warp    = instr_warp;
  assign warp_oh = 4'b0001 << warp;

  // An instruction is live only out of reset and for a running warp.
  assign active = reset & instr_valid & ~halted_q[warp];

  // Resource checks; a same-cycle push read is not credited.
  always_comb begin
    stall_cond = 1'b0;
    unique case (1'b1)
      (cls == CL_LD):
        stall_cond = (fifo_count_q == CNT_W'(FIFO_DEPTH));
      (cls == CL_MMUL):
        stall_cond = !seq_idle ||
                     (fifo_count_q < CNT_W'(PUSH_LEN));
      default: stall_cond = 1'b0;
    endcase
  end

  assign acc   = active & ~stall_cond;
  assign stall = active & stall_cond;

  // Issue strobes for the accepted instruction.
  always_comb begin
    instr_accept      = 1'b0;
    buffer_write_en   = 1'b0;
    pc_update_en      = 4'b0;
    busy_en           = 1'b0;
    threads_mask_busy = 4'b0;
    fifo_write_en     = 1'b0;
    fifo_write_reg    = 4'b0;
    if (acc) begin
      instr_accept    = 1'b1;
      buffer_write_en = 1'b1;
      if (cls != CL_HALT) pc_update_en = warp_oh;
      if (cls == CL_LD || cls == CL_ST) begin
        busy_en           = 1'b1;
        threads_mask_busy = threads_mask;
      end
      if (cls == CL_LD) begin
        fifo_write_en  = 1'b1;
        fifo_write_reg = target_reg;
      end
    end
  end

  push_sequencer #(
    .PUSH_LEN(PUSH_LEN)
  ) u_push_seq (
    .clk         (clk),
    .reset       (reset),
    .start       (acc && (cls == CL_MMUL)),
    .matmul_done (matmul_done),
    .idle        (seq_idle),
    .fifo_read_en(fifo_read_en),
    .push_en     (push_en)
  );

  // FIFO occupancy and sticky halt flags.
  always_comb begin
    fifo_count_d = fifo_count_q;
    unique case ({fifo_write_en, fifo_read_en})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
    halted_d = halted_q;
    if (acc && (cls == CL_HALT)) halted_d = halted_q | warp_oh;
  end

  // Occupancy and halt state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fifo_count_q <= '0;
      halted_q     <= 4'b0;
    end else begin
      fifo_count_q <= fifo_count_d;
      halted_q     <= halted_d;
    end
  end

  assign halted = halted_q;

`ifdef PERF_COUNTERS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating issue and stall counters.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (acc && issue_cnt_q != 16'hFFFF)
      issue_cnt_d = issue_cnt_q + 16'd1;
    if (stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign issue_count = issue_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/warp_issue_controller.md
# warp_issue_controller

Per-cycle issue sequencer inside the compute unit's warp scheduler. It classifies the selected warp's buffered instruction and drives the strobes for the instruction buffer, PC update, scoreboard, register FIFO and push unit. It runs the matmul push sequence (FIFO reads, then wait for completion) while non-matmul instructions keep issuing. It also tracks per-warp halt state.

## Interface
Parameters:
- FIFO_DEPTH, 8, capacity of the load-register FIFO.
- PUSH_LEN, 4, FIFO entries consumed by one MMUL push; must be 1..FIFO_DEPTH.
- CNT_W, $clog2(FIFO_DEPTH+1), FIFO occupancy counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- instr_valid  in  1  buffered instruction present for instr_warp.
- instr_warp  in  2  warp chosen by the warp selector this cycle.
- opcode  in  4  opcode of that instruction.
- target_reg  in  4  destination register of that instruction.
- threads_mask  in  4  thread-group mask (imm_short) of that instruction.
- matmul_done  in  1  single-cycle pulse from the push/pull unit.
- instr_accept  out  1  instruction issued this cycle.
- buffer_write_en  out  1  refill the instruction buffer for instr_warp.
- pc_update_en  out  4  one-hot PC advance for the issuing warp.
- busy_en  out  1  mark scoreboard busy (LD/ST only).
- threads_mask_busy  out  4  mask sent with busy_en.
- fifo_write_en  out  1  enqueue target_reg (LD only).
- fifo_write_reg  out  4  register enqueued.
- fifo_read_en  out  1  dequeue one register for the push.
- push_en  out  1  push unit active (PUSH and WAIT states).
- stall  out  1  valid instruction not issued this cycle.
- halted  out  4  per-warp halt flags.

## Operation
- Opcode classes (package constants): NOP=0, LD=1, ST=2, ALU=3..7, MMUL=8, HALT=15, others treated as NOP.
- Push FSM states: IDLE, PUSH, WAIT.
  - IDLE→PUSH when an MMUL is accepted.
  - PUSH: fifo_read_en=1 each cycle. The read counter runs 0..PUSH_LEN-1, then goes to WAIT.
  - WAIT→IDLE on matmul_done.
- Stall conditions, with instr_valid=1 and the warp not halted:
  - LD when fifo_count==FIFO_DEPTH. This is conservative: a same-cycle read does not count.
  - MMUL when state≠IDLE or fifo_count<PUSH_LEN.
- instr_accept = instr_valid & ~halted[instr_warp] & ~stall. Every accept asserts buffer_write_en.
- pc_update_en[instr_warp]=1 on accept, except for HALT.
- LD accept: busy_en=1, threads_mask_busy=threads_mask, fifo_write_en=1, fifo_write_reg=target_reg.
- ST accept: busy_en=1, threads_mask_busy=threads_mask. No FIFO write.
- ALU/NOP accept: strobes only, no side effects.
- HALT accept sets halted[instr_warp], which stays set until reset. Instructions from a halted warp give instr_accept=0 and stall=0 (dropped silently).
- fifo_count: +1 on write, −1 on read, unchanged when both occur in the same cycle. It never wraps; the stall rules guarantee this.
- matmul_done outside WAIT is ignored.

## Timing
- All issue strobes (instr_accept, buffer_write_en, pc_update_en, busy_en, threads_mask_busy, fifo_write_*, stall) are combinational from same-cycle inputs and registered state.
- push_en and fifo_read_en are decoded from registered state.
- MMUL accepted in cycle N: PUSH occupies cycles N+1..N+PUSH_LEN, WAIT starts at N+PUSH_LEN+1.
- matmul_done in WAIT at cycle M: IDLE at M+1, and a new MMUL can be accepted in M+1.
- ALU/LD/ST keep issuing during PUSH/WAIT. A LD and a push read can occur in the same cycle.
- Reset (reset=0 at a clock edge):
  - state=IDLE, read counter=0, fifo_count=0, halted=0.
  - All outputs are 0 in the following cycle, including while a PUSH or WAIT is in progress.

## Configuration
- PERF_COUNTERS_EN defined:
  - Adds outputs issue_count[15:0] (+1 per accept) and stall_count[15:0] (+1 per stall cycle).
  - Both saturate at 16'hFFFF and clear on reset.
- PERF_COUNTERS_EN undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Shared package sched_pkg: opcode localparams, push_state_t enum {IDLE, PUSH, WAIT}, warp_id_t (2-bit).
- Sub-module push_sequencer: owns the push FSM, read counter, fifo_read_en and push_en. Inputs: start, matmul_done. Output: idle.
- Top level: classification, stall logic, fifo_count, halt flags.

## Test plan
- Reset, then LD warp 1, target_reg=5, mask=4'b0011 → same cycle: busy_en=1, threads_mask_busy=0011, fifo_write_reg=5, pc_update_en=0010; fifo_count=1 next cycle.
- Four LDs, then MMUL warp 0 → accept; push_en=1 for 4 PUSH cycles with fifo_read_en=1 and fifo_count 4→0, then push_en held in WAIT until matmul_done; IDLE one cycle after.
- MMUL with fifo_count=3 (PUSH_LEN=4) → stall=1, instr_accept=0, no pc_update_en.
- During WAIT: a second MMUL stalls, while an ALU on warp 2 is accepted with pc_update_en=0100.
- Eight LDs with FIFO_DEPTH=8, then a 9th LD → stall=1. LD plus push read in the same cycle → fifo_count unchanged.
- HALT warp 3 → halted=1000, no pc_update_en. A later warp 3 ALU → instr_accept=0, stall=0. reset=0 mid-PUSH → all outputs 0, halted=0 the next cycle.
